// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: column FSM states,
// column drive patterns and the frame candidate encoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_e;

  localparam int unsigned CAND_W          = 5;
  localparam int unsigned CODE_ROW_WEIGHT = 4;

  // Candidate = {valid, code}; the all-zero value means no single key this frame.
  localparam logic [CAND_W-1:0] CAND_NONE = 5'b0_0000;

  function automatic logic [3:0] col_drive(input col_state_e s);
    logic [3:0] pat;
    case (s)
      COL0:    pat = 4'b1110;
      COL1:    pat = 4'b1101;
      COL2:    pat = 4'b1011;
      default: pat = 4'b0111;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] make_code(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
    return 4'(CODE_ROW_WEIGHT * int'(row_idx) + int'(col_idx));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4 asynchronous keypad row inputs.
module sync_2ff (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Rows idle high (pull-ups), so reset to the released level.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column multiplexing, ghost rejection,
// frame-level debounce and a one-cycle strobe per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 8192,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_MAX     = 4'(DEBOUNCE_SCANS);

  logic [3:0] row_s;

  sync_2ff u_sync (
    .clk (clk),
    .clr (clr),
    .d_i (row),
    .q_o (row_s)
  );

  col_state_e        state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [1:0]        total_q, total_d;
  logic [CAND_W-1:0] hit_q, hit_d;
  logic [CAND_W-1:0] prev_q, prev_d;
  logic [3:0]        stable_q, stable_d;
  logic [3:0]        code_q, code_d;
  logic              held_q, held_d;
  logic              valid_q, valid_d;

  logic              sample;
  logic [2:0]        low_cnt;
  logic [1:0]        low_row;
  logic [1:0]        base_total;
  logic [CAND_W-1:0] base_hit;
  logic [2:0]        sum;
  logic [3:0]        new_code;
  logic [CAND_W-1:0] cand;

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    total_d    = total_q;
    hit_d      = hit_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    code_d     = code_q;
    held_d     = held_q;
    valid_d    = 1'b0;
    low_cnt    = 3'd0;
    low_row    = 2'd0;
    base_total = 2'd0;
    base_hit   = CAND_NONE;
    sum        = 3'd0;
    new_code   = 4'd0;
    cand       = CAND_NONE;
    sample     = (dwell_q == DWELL_LAST);

    // Descending scan so the lowest low row is the one left in low_row.
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = 2'(r);
      end
    end
    new_code = make_code(low_row, state_q);

    if (sample) begin
      dwell_d = '0;
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = COL0;
      endcase

      // COL0 opens a new frame, so prior accumulation is discarded there.
      base_total = (state_q == COL0) ? 2'd0 : total_q;
      base_hit   = (state_q == COL0) ? CAND_NONE : hit_q;
      sum        = {1'b0, base_total} + low_cnt;
      total_d    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      hit_d      = base_hit;
      if (low_cnt != 3'd0 && (!base_hit[4] || new_code < base_hit[3:0]))
        hit_d = {1'b1, new_code};

      if (state_q == COL3) begin
        cand = (sum == 3'd1) ? hit_d : CAND_NONE;
        if (cand == prev_q) begin
          if (stable_q < DB_MAX) stable_d = stable_q + 4'd1;
        end else begin
          stable_d = 4'd1;
          prev_d   = cand;
        end
        if (stable_d == DB_MAX) begin
          if (cand[4] && !held_q) begin
            code_d  = cand[3:0];
            held_d  = 1'b1;
            valid_d = 1'b1;
          end else if (!cand[4]) begin
            held_d = 1'b0;
          end
        end
      end
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= COL0;
      dwell_q  <= '0;
      total_q  <= 2'd0;
      hit_q    <= CAND_NONE;
      prev_q   <= CAND_NONE;
      stable_q <= 4'd0;
      code_q   <= 4'd0;
      held_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      total_q  <= total_d;
      hit_q    <= hit_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      code_q   <= code_d;
      held_q   <= held_d;
      valid_q  <= valid_d;
    end
  end

  assign col       = col_drive(state_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
